// File: rtl/branch_predict_table.sv
// branch_predict_table
//   PC-indexed table of 2-bit saturating branch-direction counters for the
//   fetch stage. A lookup registers a counter snapshot that travels down the
//   downstream delay line. The resolved branch returns that snapshot on the
//   update port, and the entry is rewritten from the snapshot. A saturating
//   mispredict counter is also kept for performance debug.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low clear of all state
//   stall            fetch stall: lookup ignored, prediction registers hold
//   lookup_valid     lookup request this cycle
//   lookup_pc        PC of fetched instruction (index = pc[INDEX_BITS+1:2])
//   pred_valid       registered: prediction outputs valid
//   pred_state       registered counter snapshot (feeds delay line)
//   pred_taken       pred_state[1]
//   upd_valid        resolved branch this cycle
//   upd_pc           PC of resolved branch
//   upd_state        snapshot returned from the delay line
//   upd_taken        actual branch outcome
//   mispredict_count saturating count of mispredicted updates
//
// Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.

module branch_predict_table #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             lookup_valid,
  input  logic [PC_W-1:0]  lookup_pc,
  output logic             pred_valid,
  output logic [1:0]       pred_state,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic [1:0]       upd_state,
  input  logic             upd_taken,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            tbl [ENTRIES];
  logic [INDEX_BITS-1:0] lidx;
  logic [INDEX_BITS-1:0] uidx;
  logic [1:0]            upd_next;
  logic                  mispredict;
  logic                  bypass;

  assign lidx = lookup_pc[INDEX_BITS+1:2];
  assign uidx = upd_pc[INDEX_BITS+1:2];

  // New entry value is derived from the returned snapshot, not the live table.
  always_comb begin
    upd_next = upd_state;
    if (upd_taken) begin
      if (upd_state != 2'b11) upd_next = upd_state + 2'b01;
    end else begin
      if (upd_state != 2'b00) upd_next = upd_state - 2'b01;
    end
  end

  assign mispredict = upd_valid && (upd_state[1] != upd_taken);
  // Same-cycle lookup of the entry being written sees the written value.
  assign bypass     = upd_valid && (uidx == lidx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) tbl[i] <= 2'b01;
    end else if (upd_valid) begin
      tbl[uidx] <= upd_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_valid <= 1'b0;
      pred_state <= 2'b01;
    end else if (!stall) begin
      pred_valid <= lookup_valid;
      if (lookup_valid) pred_state <= bypass ? upd_next : tbl[lidx];
    end
  end

  assign pred_taken = pred_state[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mispredict_count <= '0;
    end else if (mispredict && (mispredict_count != '1)) begin
      mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_table.sv
module tb_branch_predict_table;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          lookup_valid;
  logic [31:0]   lookup_pc;
  logic          pred_valid;
  logic [1:0]    pred_state;
  logic          pred_taken;
  logic          upd_valid;
  logic [31:0]   upd_pc;
  logic [1:0]    upd_state;
  logic          upd_taken;
  logic [CW-1:0] mispredict_count;

  int npass  = 0;
  int ntotal = 0;

  branch_predict_table #(
    .INDEX_BITS(6),
    .PC_W(32),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .lookup_valid(lookup_valid),
    .lookup_pc(lookup_pc),
    .pred_valid(pred_valid),
    .pred_state(pred_state),
    .pred_taken(pred_taken),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_state(upd_state),
    .upd_taken(upd_taken),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        lv;
    logic [31:0] lpc;
    logic        uv;
    logic [31:0] upc;
    logic [1:0]  us;
    logic        ut;
    logic        epv;
    logic [1:0]  eps;
    logic [3:0]  ecnt;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_outputs(input string tag, input logic epv, input logic [1:0] eps,
                               input logic [3:0] ecnt);
    chk({tag, ".pred_valid"}, 16'(pred_valid), 16'(epv));
    chk({tag, ".pred_state"}, 16'(pred_state), 16'(eps));
    chk({tag, ".pred_taken"}, 16'(pred_taken), 16'(eps[1]));
    chk({tag, ".mispredict_count"}, 16'(mispredict_count), 16'(ecnt));
  endtask

  task automatic drive(input logic st, input logic lv, input logic [31:0] lpc,
                       input logic uv, input logic [31:0] upc, input logic [1:0] us,
                       input logic ut);
    stall = st; lookup_valid = lv; lookup_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_state = us; upd_taken = ut;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    idle();

    // stall, lv, lpc, uv, upc, us, ut | pv, ps, cnt
    vecs[0]  = '{1'b0, 1'b1, 32'h40,  1'b0, 32'h0,   2'b00, 1'b0, 1'b1, 2'b01, 4'd0}; // fresh entry
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h40,  2'b01, 1'b1, 1'b0, 2'b01, 4'd1}; // 01->10, mispredict
    vecs[2]  = '{1'b0, 1'b1, 32'h40,  1'b1, 32'h40,  2'b10, 1'b1, 1'b1, 2'b11, 4'd1}; // 10->11 bypass
    vecs[3]  = '{1'b0, 1'b1, 32'h140, 1'b1, 32'h40,  2'b11, 1'b1, 1'b1, 2'b11, 4'd1}; // alias + sat
    vecs[4]  = '{1'b0, 1'b1, 32'h40,  1'b0, 32'h0,   2'b00, 1'b0, 1'b1, 2'b11, 4'd1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h40,  2'b11, 1'b1, 1'b0, 2'b11, 4'd1}; // 4th update
    vecs[6]  = '{1'b0, 1'b1, 32'h43,  1'b0, 32'h0,   2'b00, 1'b0, 1'b1, 2'b11, 4'd1}; // low bits ignored
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h40,  2'b00, 1'b0, 1'b0, 2'b11, 4'd1}; // sat down
    vecs[8]  = '{1'b0, 1'b1, 32'h40,  1'b1, 32'h40,  2'b00, 1'b0, 1'b1, 2'b00, 4'd1};
    vecs[9]  = '{1'b0, 1'b1, 32'h40,  1'b0, 32'h0,   2'b00, 1'b0, 1'b1, 2'b00, 4'd1};
    vecs[10] = '{1'b0, 1'b1, 32'h80,  1'b1, 32'h80,  2'b10, 1'b1, 1'b1, 2'b11, 4'd1}; // collision
    vecs[11] = '{1'b0, 1'b1, 32'h84,  1'b1, 32'h80,  2'b11, 1'b0, 1'b1, 2'b01, 4'd2}; // diff idx
    vecs[12] = '{1'b0, 1'b1, 32'h80,  1'b0, 32'h0,   2'b00, 1'b0, 1'b1, 2'b10, 4'd2};
    vecs[13] = '{1'b0, 1'b1, 32'h80,  1'b1, 32'h80,  2'b10, 1'b1, 1'b1, 2'b11, 4'd2};
    vecs[14] = '{1'b1, 1'b1, 32'hC0,  1'b1, 32'hC0,  2'b01, 1'b0, 1'b1, 2'b11, 4'd2}; // stall + upd
    vecs[15] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   2'b00, 1'b0, 1'b1, 2'b11, 4'd2};
    vecs[16] = '{1'b0, 1'b1, 32'hC0,  1'b0, 32'h0,   2'b00, 1'b0, 1'b1, 2'b00, 4'd2}; // stall write seen
    vecs[17] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   2'b00, 1'b0, 1'b0, 2'b00, 4'd2};
    vecs[18] = '{1'b1, 1'b1, 32'h80,  1'b0, 32'h0,   2'b00, 1'b0, 1'b0, 2'b00, 4'd2}; // pv=0 held
    vecs[19] = '{1'b0, 1'b1, 32'h80,  1'b0, 32'h0,   2'b00, 1'b0, 1'b1, 2'b11, 4'd2};

    // Reset state
    repeat (3) @(posedge clk);
    #1 check_outputs("reset", 1'b0, 2'b01, 4'd0);
    @(negedge clk) reset = 1'b1;

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vecs[i].st, vecs[i].lv, vecs[i].lpc, vecs[i].uv, vecs[i].upc, vecs[i].us, vecs[i].ut);
      @(posedge clk);
      #1 check_outputs($sformatf("vec%0d", i), vecs[i].epv, vecs[i].eps, vecs[i].ecnt);
    end

    // Mispredict counter saturation: count is 2 here, 20 mispredicts pin it at 0xF
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 2'b00, 1'b1);
      @(posedge clk);
      #1 chk($sformatf("cnt_sat%0d", i), 16'(mispredict_count),
             16'((2 + i) > 15 ? 15 : (2 + i)));
    end
    @(negedge clk) idle();
    @(posedge clk);
    #1 chk("cnt_hold", 16'(mispredict_count), 16'hF);

    // Asynchronous reset mid-cycle, with an update pending
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h80, 1'b1, 32'h80, 2'b10, 1'b0);
    #2 reset = 1'b0;
    #1 check_outputs("async_reset", 1'b0, 2'b01, 4'd0);
    @(posedge clk);
    #1 check_outputs("reset_held", 1'b0, 2'b01, 4'd0);
    @(negedge clk) reset = 1'b1;
    idle();

    // Every previously written entry is back to weak not-taken
    begin
      logic [31:0] pcs [4];
      pcs[0] = 32'h40; pcs[1] = 32'h80; pcs[2] = 32'hC0; pcs[3] = 32'h100;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        drive(1'b0, 1'b1, pcs[i], 1'b0, 32'h0, 2'b00, 1'b0);
        @(posedge clk);
        #1 check_outputs($sformatf("post_reset%0d", i), 1'b1, 2'b01, 4'd0);
      end
    end
    @(negedge clk) idle();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
